// File: rtl/reg_file_mr1w.sv
// Register file with NUM_READ read ports and one write port on a single clock, with a built-in array clear sequencer.
// Latency: reads return data one cycle after the address is sampled; writes land at the sampling edge.
// Backpressure: none; oReady=0 while the clear sequencer runs, and reads, writes and iClear are ignored then.
//
// Ports:
//   iClk        clock, all state updates on posedge
//   iRst_n      asynchronous reset, active low
//   iAddrRead   packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   iEnRead     per-port read enable; a disabled port holds its last value
//   oDataRead   packed registered read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   iAddrWrite  write address
//   iDataWrite  write data
//   iEnWrite    write enable
//   iClear      one-cycle request to re-zero the whole array
//   oReady      1 while reads and writes are honoured

module reg_file_mr1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                           iClk,
  input  logic                           iRst_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] iAddrRead,
  input  logic [NUM_READ-1:0]            iEnRead,
  output logic [NUM_READ*DATA_WIDTH-1:0] oDataRead,
  input  logic [ADDR_WIDTH-1:0]          iAddrWrite,
  input  logic [DATA_WIDTH-1:0]          iDataWrite,
  input  logic                           iEnWrite,
  input  logic                           iClear,
  output logic                           oReady
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    stClear = 1'b0,
    stRun   = 1'b1
  } stateT;

  stateT                 state;
  stateT                 stateNext;
  // One bit wider than the address so the terminal count shows up as the MSB
  // setting, not as a wrap back to zero.
  logic [ADDR_WIDTH:0]   clrCnt;
  logic [ADDR_WIDTH:0]   clrCntNext;
  logic [ADDR_WIDTH:0]   clrCntInc;

  logic                  writeDiscard;
  logic                  runWrite;

  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memData;

  // Storage has no reset so it maps onto RAM; contents are defined only once
  // the clear sequence has walked every entry.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Writes to entry 0 are dropped when it is the hardwired zero register.
  assign writeDiscard = (ZERO_REG != 0) && (iAddrWrite == '0);

  // A write that coincides with iClear is dropped; the array is about to be
  // zeroed anyway and we do not want it to survive in the bypass path either.
  assign runWrite = (state == stRun) && iEnWrite && !iClear && !writeDiscard;

  assign clrCntInc = clrCnt + {{ADDR_WIDTH{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state  <= stClear;
      clrCnt <= '0;
    end else begin
      state  <= stateNext;
      clrCnt <= clrCntNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state and array write port selection
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext  = state;
    clrCntNext = clrCnt;
    memWe      = 1'b0;
    memAddr    = iAddrWrite;
    memData    = iDataWrite;

    unique case (state)
      stClear: begin
        memWe      = 1'b1;
        memAddr    = clrCnt[ADDR_WIDTH-1:0];
        memData    = '0;
        clrCntNext = clrCntInc;
        // Entry DEPTH-1 is written this cycle when the increment reaches DEPTH.
        if (clrCntInc[ADDR_WIDTH]) begin
          stateNext = stRun;
        end
      end
      stRun: begin
        memWe = runWrite;
        if (iClear) begin
          stateNext  = stClear;
          clrCntNext = '0;
        end
      end
      default: begin
        stateNext  = stClear;
        clrCntNext = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Array write
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (memWe) begin
      mem[memAddr] <= memData;
    end
  end

  assign oReady = (state == stRun);

  // ---------------------------------------------------------------------------
  // Read ports: each one is an independent registered lookup.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rdReg [NUM_READ];

  for (genvar gp = 0; gp < NUM_READ; gp++) begin : gRead
    logic [ADDR_WIDTH-1:0] rdAddr;
    logic [DATA_WIDTH-1:0] rdVal;

    assign rdAddr = iAddrRead[gp*ADDR_WIDTH +: ADDR_WIDTH];

    // Priority: zero register, then same-cycle forwarding, then the array as
    // it stood before this edge's write.
    always_comb begin
      rdVal = mem[rdAddr];
      if ((ZERO_REG != 0) && (rdAddr == '0)) begin
        rdVal = '0;
      end else if ((BYPASS != 0) && runWrite && (iAddrWrite == rdAddr)) begin
        rdVal = iDataWrite;
      end
    end

    // iClear does not block reads in its own cycle: state is still RUN there.
    // Throughout CLEAR the outputs are forced to zero.
    always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
        rdReg[gp] <= '0;
      end else if (state == stClear) begin
        rdReg[gp] <= '0;
      end else if (iEnRead[gp]) begin
        rdReg[gp] <= rdVal;
      end
    end

    assign oDataRead[gp*DATA_WIDTH +: DATA_WIDTH] = rdReg[gp];
  end

endmodule
